pool_window_gather: RTL and testbench
=====================================

POOL_WINDOW_GATHER -- requirements
Module: pool_window_gather

Interface
REQ-001 SHALL have parameter IMG_W, default 28, meaning conv output row width in samples (even, >=2).
REQ-002 SHALL have parameter IMG_H, default 28, meaning conv output rows per frame (even, >=2).
REQ-003 SHALL have parameter HOLD, default 4, meaning cycles nums_vld stays high per window (>=4).
REQ-004 SHALL have port clk  input  1  clock, rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port din_vld  input  1  conv sample valid.
REQ-007 SHALL have port din  input  16  conv sample, two's complement, raster order.
REQ-008 SHALL have port din_rdy  output  1  sample accepted when din_vld and din_rdy are both high at a rising edge.
REQ-009 SHALL have port nums_vld  output  1  2x2 window valid, feeds the downstream relu/pool stage.
REQ-010 SHALL have ports num1, num2, num3, num4  output  16 each  window top-left, top-right, bottom-left, bottom-right.
REQ-011 SHALL have port frame_done  output  1  one-cycle pulse after the last window of a frame.

Function
REQ-012 SHALL keep column counter col (0..IMG_W-1) and row counter row (0..IMG_H-1), advanced only on accepted samples; col wraps to 0 and row increments at col=IMG_W-1; row wraps to 0 after the last pixel of the frame.
REQ-013 SHALL store every accepted sample of an even row into a line buffer of IMG_W x 16 bits at index col.
REQ-014 SHALL, on an odd row at even col, hold the accepted sample in a 16-bit register as the bottom-left value.
REQ-015 SHALL, on an odd row at odd col c, form the window: num1=buf[c-1], num2=buf[c], num3=held bottom-left, num4=accepted sample.
REQ-016 SHALL implement a three-state FSM: COLLECT, HOLD, GAP.
REQ-017 COLLECT: din_rdy=1, nums_vld=0; acceptance of a window-completing sample (REQ-015) SHALL register num1..num4 and move to HOLD at that edge.
REQ-018 HOLD: nums_vld=1 for exactly HOLD consecutive cycles, din_rdy=0, num1..num4 stable; then move to GAP.
REQ-019 GAP: exactly one cycle with nums_vld=0, din_rdy=0; then return to COLLECT.
REQ-020 frame_done SHALL pulse high during the GAP cycle of the window completed at row=IMG_H-1, col=IMG_W-1; low at all other times.
REQ-021 Latency: nums_vld SHALL rise on the first rising edge after the window-completing sample is accepted.
REQ-022 num1..num4 SHALL hold their last window values outside HOLD (not cleared), except on reset.
REQ-023 din_vld low in COLLECT SHALL leave counters, buffer, and state unchanged; din SHALL be ignored whenever din_rdy=0.
REQ-024 Samples not completing a window SHALL be accepted back-to-back in COLLECT with no stall.
REQ-025 Line buffer contents SHALL be overwritten in the next even row; no clearing is needed between frames.

Reset
REQ-026 While rst is high, state SHALL be COLLECT; col, row=0; din_rdy=1; nums_vld=0; frame_done=0; num1..num4=0; held bottom-left=0.
REQ-027 rst asserted mid-HOLD or GAP SHALL abort the window immediately; after release, the first accepted sample is treated as row 0, col 0.
REQ-028 Line buffer contents SHALL NOT require reset.

Verification
REQ-029 IMG_W=4, IMG_H=2, HOLD=4; stream 1,2,3,4,5,6,7,8 with din_vld always high -> window (1,2,5,6) with nums_vld high 4 cycles, 1 gap cycle, then window (3,4,7,8); frame_done pulses once in the final GAP.
REQ-030 Same config: din_rdy low for exactly 5 cycles after acceptance of samples 6 and 8; samples 1-5 and 7 accepted back-to-back.
REQ-031 Negative values: row0=0xFF80,0x0010,..., row1=0x8000,0x7FFF,... -> num1..num4 = 0xFF80,0x0010,0x8000,0x7FFF unmodified.
REQ-032 din_vld toggled 1,0,1,0 during COLLECT -> identical windows to REQ-029; counters advance only on handshakes.
REQ-033 rst pulsed during the 2nd HOLD cycle of window (1,2,5,6) -> nums_vld=0, din_rdy=1 next cycle; restreaming 1..8 reproduces REQ-029 exactly.
REQ-034 Two consecutive frames at default IMG_W=IMG_H=28 -> 196 windows per frame, exactly two frame_done pulses, each window matching a reference model.

Source files
------------

// File: rtl/pool_window_gather.sv
// Gathers a raster stream of conv samples into non-overlapping 2x2 windows and
// presents each window for HOLD cycles, followed by a one-cycle gap, to the pool stage.
module pool_window_gather #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int HOLD  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        din_vld,
  input  logic [15:0] din,
  output logic        din_rdy,
  output logic        nums_vld,
  output logic [15:0] num1,
  output logic [15:0] num2,
  output logic [15:0] num3,
  output logic [15:0] num4,
  output logic        frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int HW = $clog2(HOLD);
  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);

  typedef enum logic [1:0] {S_COLLECT, S_HOLD, S_GAP} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] col_reg;
  logic [RW-1:0] row_reg;
  logic [HW-1:0] hold_cnt_reg;
  logic [15:0]   bl_reg;
  logic          last_reg;
  logic [15:0]   line_buf [IMG_W];

  logic accept;
  logic win_done;

  // Acceptance depends only on registered state, keeping din_rdy free of input paths.
  assign accept   = din_vld && (state_reg == S_COLLECT);
  assign win_done = accept && row_reg[0] && col_reg[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_reg <= '0;
      row_reg <= '0;
    end else if (accept) begin
      if (col_reg == COL_LAST) begin
        col_reg <= '0;
        row_reg <= (row_reg == ROW_LAST) ? '0 : row_reg + RW'(1);
      end else begin
        col_reg <= col_reg + CW'(1);
      end
    end
  end

  // Top row of each window pair; contents persist across frames and reset.
  always_ff @(posedge clk) begin
    if (accept && !row_reg[0])
      line_buf[col_reg] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bl_reg   <= '0;
      num1     <= '0;
      num2     <= '0;
      num3     <= '0;
      num4     <= '0;
      last_reg <= 1'b0;
    end else begin
      if (accept && row_reg[0] && !col_reg[0])
        bl_reg <= din;
      if (win_done) begin
        num1     <= line_buf[col_reg - CW'(1)];
        num2     <= line_buf[col_reg];
        num3     <= bl_reg;
        num4     <= din;
        last_reg <= (row_reg == ROW_LAST) && (col_reg == COL_LAST);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= S_COLLECT;
      hold_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      hold_cnt_reg <= (state_reg == S_HOLD) ? hold_cnt_reg + HW'(1) : '0;
    end
  end

  always_comb begin
    state_next = state_reg;
    din_rdy    = 1'b0;
    nums_vld   = 1'b0;
    frame_done = 1'b0;
    case (state_reg)
      S_COLLECT: begin
        din_rdy = 1'b1;
        if (win_done)
          state_next = S_HOLD;
      end
      S_HOLD: begin
        nums_vld = 1'b1;
        if (hold_cnt_reg == HOLD_LAST)
          state_next = S_GAP;
      end
      S_GAP: begin
        frame_done = last_reg;
        state_next = S_COLLECT;
      end
      default: state_next = S_COLLECT;
    endcase
  end

endmodule

// File: tb/tb_pool_window_gather.sv
// Scoreboard bench: a small 4x2 instance for directed vectors and a default
// 28x28 instance streamed for two frames against a window model.
module tb_pool_window_gather;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic        a_rst, a_vld, a_rdy, a_nv, a_fd;
  logic [15:0] a_din, a_n1, a_n2, a_n3, a_n4;
  logic        b_rst, b_vld, b_rdy, b_nv, b_fd;
  logic [15:0] b_din, b_n1, b_n2, b_n3, b_n4;

  pool_window_gather #(.IMG_W(4), .IMG_H(2), .HOLD(4)) dut_a (
    .clk(clk), .rst(a_rst), .din_vld(a_vld), .din(a_din), .din_rdy(a_rdy),
    .nums_vld(a_nv), .num1(a_n1), .num2(a_n2), .num3(a_n3), .num4(a_n4),
    .frame_done(a_fd)
  );

  pool_window_gather dut_b (
    .clk(clk), .rst(b_rst), .din_vld(b_vld), .din(b_din), .din_rdy(b_rdy),
    .nums_vld(b_nv), .num1(b_n1), .num2(b_n2), .num3(b_n3), .num4(b_n4),
    .frame_done(b_fd)
  );

  logic [63:0] a_q[$];
  logic [63:0] b_q[$];
  int a_fd_cnt = 0;
  int b_fd_cnt = 0;
  int b_win_cnt = 0;

  function automatic void check(string name, logic [79:0] act, logic [79:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Monitor for the small instance: window contents, stability, hold length, frame_done.
  initial begin : mon_a
    int run;
    logic prev;
    logic [63:0] cur;
    run = 0; prev = 1'b0; cur = '0;
    forever begin
      @(negedge clk);
      if (a_rst) begin
        run = 0; prev = 1'b0;
      end else begin
        if (a_nv && !prev) begin
          cur = {a_n1, a_n2, a_n3, a_n4};
          if (a_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL a_win: window %h with no expected entry", cur);
          end else begin
            check("a_win", cur, a_q.pop_front());
          end
        end else if (a_nv && prev) begin
          check("a_stable", {a_n1, a_n2, a_n3, a_n4}, cur);
        end
        if (a_nv) run++;
        else if (prev) begin
          check("a_hold_len", run, 4);
          run = 0;
        end
        if (a_fd) begin
          a_fd_cnt++;
          check("a_fd_in_gap", {a_nv, a_rdy}, 0);
        end
        prev = a_nv;
      end
    end
  end

  initial begin : mon_b
    int run;
    logic prev;
    run = 0; prev = 1'b0;
    forever begin
      @(negedge clk);
      if (b_rst) begin
        run = 0; prev = 1'b0;
      end else begin
        if (b_nv && !prev) begin
          b_win_cnt++;
          if (b_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL b_win: window %h with no expected entry", {b_n1, b_n2, b_n3, b_n4});
          end else begin
            check("b_win", {b_n1, b_n2, b_n3, b_n4}, b_q.pop_front());
          end
        end
        if (b_nv) run++;
        else if (prev) begin
          check("b_hold_len", run, 4);
          run = 0;
        end
        if (b_fd) b_fd_cnt++;
        prev = b_nv;
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_a(input logic [15:0] v, input bit gap, output int stall);
    stall = 0;
    a_din = v; a_vld = 1'b1;
    while (!a_rdy && stall < 50) begin @(negedge clk); stall++; end
    @(negedge clk);
    if (gap) begin a_vld = 1'b0; a_din = 16'hDEAD; @(negedge clk); end
  endtask

  task automatic send_b(input logic [15:0] v);
    int w;
    w = 0;
    b_din = v; b_vld = 1'b1;
    while (!b_rdy && w < 50) begin @(negedge clk); w++; end
    if (w >= 50) begin n_cmp++; n_err++; $display("FAIL b_accept: timeout waiting din_rdy"); end
    @(negedge clk);
  endtask

  task automatic wait_rdy_a(output int n);
    n = 0;
    while (!a_rdy && n < 50) begin @(negedge clk); n++; end
  endtask

  // Stream 1..8; sample 7 waits out the first window, the last sample is followed by five idle cycles.
  task automatic stream_basic_a(input bit gap, input bit chk_stall);
    int st;
    a_q.push_back({16'd1, 16'd2, 16'd5, 16'd6});
    a_q.push_back({16'd3, 16'd4, 16'd7, 16'd8});
    for (int i = 1; i <= 8; i++) begin
      send_a(16'(i), gap, st);
      if (chk_stall) check($sformatf("a_stall_s%0d", i), st, (i == 7) ? 5 : 0);
    end
    a_vld = 1'b0;
    wait_rdy_a(st);
    if (chk_stall) check("a_tail_stall", st, 5);
    else check("a_tail_bounded", st < 50, 1);
  endtask

  logic [15:0] top_row [28];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit exceeded");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int st;
    logic [15:0] v, bl;
    a_rst = 1'b1; a_vld = 1'b0; a_din = '0;
    b_rst = 1'b1; b_vld = 1'b0; b_din = '0;
    bl = '0;
    repeat (2) @(negedge clk);
    check("a_reset_out", {a_rdy, a_nv, a_fd, a_n1, a_n2, a_n3, a_n4}, {3'b100, 64'h0});
    check("b_reset_out", {b_rdy, b_nv, b_fd, b_n1, b_n2, b_n3, b_n4}, {3'b100, 64'h0});
    a_rst = 1'b0; b_rst = 1'b0;
    @(negedge clk);

    // Basic stream with back-to-back acceptance and stall timing.
    a_fd_cnt = 0;
    stream_basic_a(1'b0, 1'b1);
    check("a_fd_count_basic", a_fd_cnt, 1);

    // Signed extremes pass through untouched.
    a_fd_cnt = 0;
    a_q.push_back({16'hFF80, 16'h0010, 16'h8000, 16'h7FFF});
    a_q.push_back({16'h1234, 16'h5678, 16'hFFFF, 16'h0001});
    send_a(16'hFF80, 1'b0, st); send_a(16'h0010, 1'b0, st);
    send_a(16'h1234, 1'b0, st); send_a(16'h5678, 1'b0, st);
    send_a(16'h8000, 1'b0, st); send_a(16'h7FFF, 1'b0, st);
    send_a(16'hFFFF, 1'b0, st); send_a(16'h0001, 1'b0, st);
    a_vld = 1'b0;
    wait_rdy_a(st);
    check("a_fd_count_neg", a_fd_cnt, 1);

    // din_vld toggling: same windows, counters only move on handshakes.
    a_fd_cnt = 0;
    stream_basic_a(1'b1, 1'b0);
    check("a_fd_count_toggle", a_fd_cnt, 1);

    // Reset during the second HOLD cycle aborts the window; restream reproduces the basic run.
    a_fd_cnt = 0;
    a_q.push_back({16'd1, 16'd2, 16'd5, 16'd6});
    for (int i = 1; i <= 6; i++) send_a(16'(i), 1'b0, st);
    a_vld = 1'b0;
    @(posedge clk);
    #1 a_rst = 1'b1;
    @(negedge clk);
    check("a_midhold_reset", {a_rdy, a_nv, a_fd, a_n1, a_n2, a_n3, a_n4}, {3'b100, 64'h0});
    a_rst = 1'b0;
    @(negedge clk);
    check("a_after_reset", {a_rdy, a_nv}, 2'b10);
    stream_basic_a(1'b0, 1'b1);
    check("a_fd_count_rst", a_fd_cnt, 1);
    check("a_queue_empty", a_q.size(), 0);

    // Two full default-size frames against the window model.
    for (int f = 0; f < 2; f++) begin
      for (int r = 0; r < 28; r++) begin
        for (int c = 0; c < 28; c++) begin
          v = 16'($urandom);
          if (r % 2 == 0) top_row[c] = v;
          else if (c % 2 == 0) bl = v;
          else b_q.push_back({top_row[c-1], top_row[c], bl, v});
          send_b(v);
        end
      end
    end
    b_vld = 1'b0;
    st = 0;
    while ((!b_rdy || b_q.size() != 0) && st < 50) begin @(negedge clk); st++; end
    repeat (2) @(negedge clk);
    check("b_win_count", b_win_cnt, 392);
    check("b_fd_count", b_fd_cnt, 2);
    check("b_queue_empty", b_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
